// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package rr_mux_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between the requesting sources and the arbiter.
interface rr_mux_arbiter_if;
    import rr_mux_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   select;
    logic               busy;

    modport master (output req, input grant, input select, input busy);
    modport slave  (input req, output grant, output select, output busy);

endinterface

// File: rtl/rr_mux_arbiter_picker.sv
// Rotating-priority picker: first unmasked request at or above the pointer, wrapping mod 4.
module rr_priority_picker
    import rr_mux_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [IDX_W-1:0]   i_pointer,
    output logic [IDX_W-1:0]   o_winIdx,
    output logic               o_found
);

    logic [NUM_REQ-1:0] w_cand;
    logic [IDX_W-1:0]   w_idx;

    // Scanning from the far end lets the candidate closest to the pointer overwrite the rest.
    always_comb begin
        w_cand   = i_req & ~i_mask;
        w_idx    = '0;
        o_winIdx = '0;
        o_found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = i_pointer + IDX_W'(k);
            if (w_cand[w_idx]) begin
                o_winIdx = w_idx;
                o_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of a shared four-way mux; drives a registered one-hot grant and select.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    rr_mux_arbiter_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IDX_W-1:0]    r_select;
    logic [IDX_W-1:0]    r_pointer;
    logic                r_busy;
    logic [HOLD_W-1:0]   r_holdCnt;

    logic [IDX_W-1:0]    w_pickPtr;
    logic [NUM_REQ-1:0]  w_pickMask;
    logic [IDX_W-1:0]    w_winIdx;
    logic                w_found;
    logic                w_ownerReq;
    logic                w_othersReq;
    logic                w_forced;

    // While granted, the picker already looks past the owner so a release re-arbitrates with no bubble.
    assign w_pickPtr   = (r_state == ST_GRANT) ? r_select + IDX_W'(1) : r_pointer;
    assign w_pickMask  = (r_state == ST_GRANT) ? r_grant : '0;
    assign w_ownerReq  = bus.req[r_select];
    assign w_othersReq = |(bus.req & ~r_grant);
    assign w_forced    = (MAX_HOLD != 0) && (r_holdCnt == HOLD_LIM) && w_othersReq;

    rr_priority_picker u_picker (
        .i_req     (bus.req),
        .i_mask    (w_pickMask),
        .i_pointer (w_pickPtr),
        .o_winIdx  (w_winIdx),
        .o_found   (w_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_select  <= '0;
            r_pointer <= '0;
            r_busy    <= 1'b0;
            r_holdCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant   <= onehot(w_winIdx);
                        r_select  <= w_winIdx;
                        r_busy    <= 1'b1;
                        r_holdCnt <= HOLD_W'(1);
                        r_state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_ownerReq && !w_forced) begin
                        if ((MAX_HOLD != 0) && (r_holdCnt != HOLD_LIM)) begin
                            r_holdCnt <= r_holdCnt + HOLD_W'(1);
                        end
                    end else begin
                        r_pointer <= r_select + IDX_W'(1);
                        if (w_found) begin
                            r_grant   <= onehot(w_winIdx);
                            r_select  <= w_winIdx;
                            r_holdCnt <= HOLD_W'(1);
                        end else begin
                            r_grant   <= '0;
                            r_busy    <= 1'b0;
                            r_holdCnt <= '0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant  = r_grant;
    assign bus.select = r_select;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with MAX_HOLD=4 and a modelled four-way mux on the select output.
module tb_rr_mux_arbiter;

    logic clk;
    logic rst;
    int   assertions;
    int   failures;

    logic [3:0] patStep;
    logic [3:0] muxIn [4];
    logic [3:0] muxOut;

    rr_mux_arbiter_if bus ();

    rr_mux_arbiter #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mux test pattern: each input steps through 0000..1111, offset per input.
    always @(posedge clk) patStep <= patStep + 4'd1;
    always_comb begin
        for (int k = 0; k < 4; k++) muxIn[k] = patStep + 4'(k);
    end
    assign muxOut = muxIn[bus.select];

    // Whenever busy, the mux must route the input belonging to the one-hot grant owner.
    always @(negedge clk) begin
        if (bus.busy === 1'b1) begin
            int gi;
            gi = 0;
            for (int k = 0; k < 4; k++) if (bus.grant[k]) gi = k;
            assertions++;
            if ($countones(bus.grant) != 1 || muxOut !== muxIn[gi]) begin
                failures++;
                $display("[TB] FAIL mux_route: grant=%b select=%0d out=%h required=%h",
                         bus.grant, bus.select, muxOut, muxIn[gi]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.req = 4'b1111;
        tick();
        assertions++;
        if (bus.grant !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL pre_reset_grant: got %b required %b", bus.grant, 4'b0001);
        end
        #2;
        rst = 1'b1;
        #1;
        assertions++;
        if (bus.grant !== 4'b0000 || bus.select !== 2'b00 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset: got grant=%b select=%b busy=%b required 0000/00/0",
                     bus.grant, bus.select, bus.busy);
        end
        bus.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        tick();
        assertions++;
        if (bus.grant !== 4'b0100 || bus.select !== 2'b10 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_grant: got grant=%b select=%b busy=%b required 0100/10/1",
                     bus.grant, bus.select, bus.busy);
        end
        tick();
        tick();
        bus.req = 4'b0000;
        tick();
        assertions++;
        if (bus.grant !== 4'b0000 || bus.select !== 2'b10 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_release: got grant=%b select=%b busy=%b required 0000/10/0",
                     bus.grant, bus.select, bus.busy);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] expGrant [5];
        logic [1:0] expSel   [5];
        expGrant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        expSel   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        pulseReset();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            assertions++;
            if (bus.grant !== expGrant[i] || bus.select !== expSel[i] || bus.busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rotation_%0d: got grant=%b select=%0d busy=%b required %b/%0d/1",
                         i, bus.grant, bus.select, bus.busy, expGrant[i], expSel[i]);
            end
            bus.req = 4'b1111 & ~expGrant[i];
        end
        bus.req = 4'b0000;
        tick();
        assertions++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rotation_idle: got grant=%b busy=%b required 0000/0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_hold_limit();
        pulseReset();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            assertions++;
            if (bus.grant !== 4'b0001) begin
                failures++;
                $display("[TB] FAIL hold_keep_%0d: got %b required 0001", i, bus.grant);
            end
            tick();
        end
        assertions++;
        if (bus.grant !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL hold_keep_3: got %b required 0001", bus.grant);
        end
        tick();
        assertions++;
        if (bus.grant !== 4'b0100 || bus.select !== 2'b10) begin
            failures++;
            $display("[TB] FAIL hold_forced: got grant=%b select=%b required 0100/10", bus.grant, bus.select);
        end
        tick();
        bus.req = 4'b0001;
        tick();
        assertions++;
        if (bus.grant !== 4'b0001 || bus.select !== 2'b00 || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_return: got grant=%b select=%b busy=%b required 0001/00/1",
                     bus.grant, bus.select, bus.busy);
        end
    endtask

    task automatic test_lone_holder();
        int bad;
        bad = 0;
        bus.req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.grant !== 4'b0001) bad++;
        end
        assertions++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL lone_grant: %0d of 20 cycles lost grant, required 0", bad);
        end
        assertions++;
        if (dut.r_holdCnt !== 3'd4) begin
            failures++;
            $display("[TB] FAIL lone_saturate: hold count %0d required 4", dut.r_holdCnt);
        end
        bus.req = 4'b0000;
        tick();
        assertions++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.select !== 2'b00) begin
            failures++;
            $display("[TB] FAIL lone_release: got grant=%b busy=%b select=%b required 0000/0/00",
                     bus.grant, bus.busy, bus.select);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, required run to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertions = 0;
        failures   = 0;
        patStep    = 4'd0;
        rst        = 1'b1;
        bus.req    = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        $display("[TB] starting directed tests");
        test_reset();
        test_single();
        test_rotation();
        test_hold_limit();
        test_lone_holder();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
